seg7_scan_mux: RTL and testbench

Parametrised time-multiplexed 7-segment display driver for NUM_DIGITS common-anode digits. Decodes full hex (0-F) per digit and adds per-digit decimal point and blanking. Inserts an anti-ghosting dead time between digits and freezes each digit's value for the duration of its slot. Sits between the BCD/keypad datapath and the board display pins.

---
 rtl/seg7_scan_mux_if.sv | 28 ++
 rtl/seg7_scan_mux.sv | 127 ++++++++++++
 tb/tb_seg7_scan_mux.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle for seg7_scan_mux: scan control, per-digit data and the pin-level outputs.
// The blink_mask signal exists only when SEG7_BLINK_EN is defined.
interface seg7_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      en;
   logic [4*NUM_DIGITS-1:0]   value;
   logic [NUM_DIGITS-1:0]     dp;
   logic [NUM_DIGITS-1:0]     blank;
`ifdef SEG7_BLINK_EN
   logic [NUM_DIGITS-1:0]     blink_mask;
`endif
   logic [NUM_DIGITS-1:0]     DIGIT;
   logic [7:0]                DISPLAY;
   logic                      frame_start;

`ifdef SEG7_BLINK_EN
   modport master (output en, value, dp, blank, blink_mask,
                   input  DIGIT, DISPLAY, frame_start);
   modport slave  (input  en, value, dp, blank, blink_mask,
                   output DIGIT, DISPLAY, frame_start);
`else
   modport master (output en, value, dp, blank,
                   input  DIGIT, DISPLAY, frame_start);
   modport slave  (input  en, value, dp, blank,
                   output DIGIT, DISPLAY, frame_start);
`endif
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: hex decode, per-digit dp/blank, dead time per slot.
// Optional digit blinking is compiled in with SEG7_BLINK_EN.
module seg7_scan_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1024,
   parameter int BLANK_CYC  = 16
`ifdef SEG7_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 64
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   seg7_scan_mux_if.slave  bus
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [3:0]            lat_nib;
   logic                  lat_dp;
   logic                  lat_blank;
   logic                  dark_now;
   logic [NUM_DIGITS-1:0] dig_q;
   logic [7:0]            disp_q;
   logic                  fs_q;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'h0: seg_decode = 7'h40;
         4'h1: seg_decode = 7'h79;
         4'h2: seg_decode = 7'h24;
         4'h3: seg_decode = 7'h30;
         4'h4: seg_decode = 7'h19;
         4'h5: seg_decode = 7'h12;
         4'h6: seg_decode = 7'h02;
         4'h7: seg_decode = 7'h78;
         4'h8: seg_decode = 7'h00;
         4'h9: seg_decode = 7'h10;
         4'hA: seg_decode = 7'h08;
         4'hB: seg_decode = 7'h03;
         4'hC: seg_decode = 7'h46;
         4'hD: seg_decode = 7'h21;
         4'hE: seg_decode = 7'h06;
         default: seg_decode = 7'h0E;
      endcase
   endfunction

`ifdef SEG7_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [FW-1:0] FRM_RELOAD = FW'(BLINK_FRAMES - 1);
   localparam logic [FW-1:0] FRM_INIT   = FW'(BLINK_FRAMES);
   logic [FW-1:0] frm_tmr;
   logic          blink_phase;
   logic          lat_blink;

   // Phase only toggles at a digit-0 slot start, so it is stable across any single slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_tmr     <= FRM_INIT;
         blink_phase <= 1'b0;
         lat_blink   <= 1'b0;
      end else if (bus.en && (cnt == '0)) begin
         lat_blink <= bus.blink_mask[idx];
         if (idx == '0) begin
            if (frm_tmr == '0) begin
               frm_tmr     <= FRM_RELOAD;
               blink_phase <= ~blink_phase;
            end else begin
               frm_tmr <= frm_tmr - 1'b1;
            end
         end
      end
   end

   assign dark_now = lat_blank | (blink_phase & lat_blink);
`else
   assign dark_now = lat_blank;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         idx       <= '0;
         lat_nib   <= '0;
         lat_dp    <= 1'b0;
         lat_blank <= 1'b0;
         dig_q     <= '1;
         disp_q    <= 8'hFF;
         fs_q      <= 1'b0;
      end else if (bus.en) begin
         if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (cnt == '0) begin
            lat_nib   <= bus.value[{idx, 2'b00} +: 4];
            lat_dp    <= bus.dp[idx];
            lat_blank <= bus.blank[idx];
         end
         fs_q <= (cnt == '0) && (idx == '0);
         // BLANK_CYC >= 1 keeps the latch cycle dark, so fresh latch data is never needed early.
         if ((cnt < BLANK_LIM) || dark_now) begin
            dig_q  <= '1;
            disp_q <= 8'hFF;
         end else begin
            dig_q  <= ~(SEL_ONE << idx);
            disp_q <= {~lat_dp, seg_decode(lat_nib)};
         end
      end else begin
         dig_q  <= '1;
         disp_q <= 8'hFF;
         fs_q   <= 1'b0;
      end
   end

   assign bus.DIGIT       = dig_q;
   assign bus.DISPLAY     = disp_q;
   assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: literal frame checks, async reset check, then random stimulus vs a time-based model.
module tb_seg7_scan_mux;
   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BC = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef SEG7_BLINK_EN
   initial bus.blink_mask = '0;
`endif

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: t counts enabled clocks since reset; slot and position follow by division.
   int          t = 0;
   logic [3:0]  m_nib = '0;
   logic        m_dp = 1'b0;
   logic        m_blank = 1'b0;
   logic [ND-1:0] exp_digit = '1;
   logic [7:0]  exp_disp = 8'hFF;
   logic        exp_fs = 1'b0;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t = 0; m_nib = '0; m_dp = 1'b0; m_blank = 1'b0;
         exp_digit = '1; exp_disp = 8'hFF; exp_fs = 1'b0;
      end else if (bus.en) begin
         int pos, d;
         pos = t % SD;
         d   = (t / SD) % ND;
         if (pos == 0) begin
            m_nib   = bus.value[4*d +: 4];
            m_dp    = bus.dp[d];
            m_blank = bus.blank[d];
         end
         exp_fs = (pos == 0) && (d == 0);
         if (pos < BC || m_blank) begin
            exp_digit = '1; exp_disp = 8'hFF;
         end else begin
            exp_digit = '1;
            exp_digit[d] = 1'b0;
            exp_disp = {~m_dp, seg_tab[m_nib]};
         end
         t = t + 1;
      end else begin
         exp_digit = '1; exp_disp = 8'hFF; exp_fs = 1'b0;
      end
   end

   always @(negedge clk) begin
      check("digit", 32'(bus.DIGIT), 32'(exp_digit));
      check("display", 32'(bus.DISPLAY), 32'(exp_disp));
      check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
      check("one_digit_max", 32'($countones(~bus.DIGIT) <= 1), 32'd1);
   end

   logic [7:0]  lit_tab [3][4] = '{'{8'hF9, 8'hF8, 8'h88, 8'hB0},
                                   '{8'hF9, 8'h78, 8'hFF, 8'hB0},
                                   '{8'h92, 8'h78, 8'hFF, 8'hB0}};
   logic [3:0]  sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

   initial begin
      bus.en = 1'b1;
      bus.value = 16'h3A71;
      bus.dp = '0;
      bus.blank = '0;
      repeat (3) @(negedge clk);
      check("reset_digit", 32'(bus.DIGIT), 32'hF);
      check("reset_display", 32'(bus.DISPLAY), 32'hFF);
      check("reset_fs", 32'(bus.frame_start), 32'h0);
      rst_n = 1'b1;

      for (int k = 1; k <= 48; k++) begin
         int fr, dg, pos;
         @(posedge clk); #1;
         fr  = (k - 1) / 16;
         dg  = ((k - 1) / 4) % 4;
         pos = (k - 1) % 4;
         check("lit_fs", 32'(bus.frame_start), 32'((pos == 0 && dg == 0) ? 1 : 0));
         if (pos == 0 || lit_tab[fr][dg] == 8'hFF) begin
            check("lit_digit", 32'(bus.DIGIT), 32'hF);
            check("lit_display", 32'(bus.DISPLAY), 32'hFF);
         end else begin
            check("lit_digit", 32'(bus.DIGIT), 32'(sel_tab[dg]));
            check("lit_display", 32'(bus.DISPLAY), 32'(lit_tab[fr][dg]));
         end
         if (k == 18) begin
            bus.value[3:0] = 4'h5;
            bus.dp = 4'b0010;
            bus.blank = 4'b0100;
         end
      end

      // Async reset during a lit slot must darken immediately.
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_digit", 32'(bus.DIGIT), 32'hF);
      check("async_rst_display", 32'(bus.DISPLAY), 32'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_dark", 32'(bus.DISPLAY), 32'hFF);
      check("post_rst_fs", 32'(bus.frame_start), 32'h1);
      @(posedge clk); #1;
      check("post_rst_digit0", 32'(bus.DIGIT), 32'hE);
      check("post_rst_disp0", 32'(bus.DISPLAY), 32'h92);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.en = ($urandom_range(0, 11) != 0);
         if ($urandom_range(0, 7) == 0) bus.value = 16'($urandom);
         if ($urandom_range(0, 15) == 0) bus.dp = 4'($urandom);
         if ($urandom_range(0, 15) == 0) bus.blank = 4'($urandom) & 4'($urandom);
         if (c == 1500) begin
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("rand_rst_digit", 32'(bus.DIGIT), 32'hF);
            check("rand_rst_display", 32'(bus.DISPLAY), 32'hFF);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
